// File: rtl/encap_pkg.sv
// encap_pkg: shared definitions for the encap_packet_mc slice.
//   - encap_state_e : FSM state encoding (IDLE / SEND)
//   - clog2_min1    : ceil(log2(v)), never less than 1
//   - ceil_div      : integer ceiling division
//   - calc_seq_w    : width of the beat sequence field
//   - calc_num_packet : number of beats per frame
// The sequence field lives inside the beat header, so its width shrinks the
// payload, which can raise the beat count, which can widen the field again.
// calc_seq_w resolves that loop by picking the smallest width that can count
// every beat of the frame it produces.
package encap_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } encap_state_e;

   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int calc_seq_w(input int dfx_w, input int rid_w,
                                     input int ttl_w, input int aur_w);
      int   seq_w;
      logic found;
      seq_w = 1;
      found = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (!found &&
             clog2_min1(ceil_div(dfx_w, aur_w - rid_w - ttl_w - c)) <= c) begin
            seq_w = c;
            found = 1'b1;
         end
      end
      return seq_w;
   endfunction

   function automatic int calc_num_packet(input int dfx_w, input int rid_w,
                                          input int ttl_w, input int aur_w);
      return ceil_div(dfx_w,
                      aur_w - rid_w - ttl_w - calc_seq_w(dfx_w, rid_w, ttl_w, aur_w));
   endfunction

endpackage

// File: rtl/encap_rr_arbiter.sv
// encap_rr_arbiter: round-robin arbiter over NUM_CH requesters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : the current grant was taken; move the search start past it
//   grant      : one-hot grant (combinational, zero when no request)
//   index      : binary index of the granted channel
// The search starts at ptr_q; after reset ptr_q is 0.
module encap_rr_arbiter
   import encap_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             req,
   input  logic                          advance,
   output logic [NUM_CH-1:0]             grant,
   output logic [clog2_min1(NUM_CH)-1:0] index
);

   localparam int IDX_W = clog2_min1(NUM_CH);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic             found;
   int               j;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            index    = IDX_W'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = (index == IDX_W'(NUM_CH - 1)) ? '0 : index + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/encap_packet_mc.sv
// encap_packet_mc: multi-channel frame encapsulator.
// A granted channel's {addr, data} frame is captured, then streamed out as
// NUMBER_PACKET beats of {router_id, seq, ttl, payload}, LSB slice first.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ch_req            : per-channel frame request (hold until ch_grant)
//   ch_data/ch_addr   : flattened per-channel frame data / destination
//   ch_router_id/ttl  : flattened per-channel header fields
//   ch_grant          : one-cycle pulse, the cycle after capture
//   data_send         : output beat; data_encap_valid / data_ready handshake
//   encap_done        : one-cycle pulse after the last-beat handshake
//   encap_ch          : channel in service
//   busy              : high while sending
//   frame_count       : completed-frame counter (only with ENCAP_PACKET_MC_STATS_EN)
//   state_dbg         : FSM state (0 = IDLE, 1 = SEND)
// Handshake: a beat transfers on a cycle where data_encap_valid && data_ready;
// while valid is high and ready is low, data_send and encap_ch hold steady.
module encap_packet_mc
   import encap_pkg::*;
#(
   parameter int DATA_WIDTH             = 1024,
   parameter int ADDR_WIDTH             = 10,
   parameter int NUM_CH                 = 4,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2,
   parameter int TTL_WIDTH              = 2,
   parameter int AURORA_DATA_WIDTH      = 64
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CH-1:0]                      ch_req,
   input  logic [NUM_CH*DATA_WIDTH-1:0]           ch_data,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]           ch_addr,
   input  logic [NUM_CH*RECOGNIZE_ROUTER_WIDTH-1:0] ch_router_id,
   input  logic [NUM_CH*TTL_WIDTH-1:0]            ch_ttl,
   output logic [NUM_CH-1:0]                      ch_grant,
   output logic [AURORA_DATA_WIDTH-1:0]           data_send,
   output logic                                   data_encap_valid,
   input  logic                                   data_ready,
   output logic                                   encap_done,
   output logic [clog2_min1(NUM_CH)-1:0]          encap_ch,
   output logic                                   busy,
`ifdef ENCAP_PACKET_MC_STATS_EN
   output logic [15:0]                            frame_count,
`endif
   output logic                                   state_dbg
);

   localparam int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH;
   localparam int SEQ_W          = calc_seq_w(DATA_DFX_WIDTH, RECOGNIZE_ROUTER_WIDTH,
                                              TTL_WIDTH, AURORA_DATA_WIDTH);
   localparam int HEADER_WIDTH   = RECOGNIZE_ROUTER_WIDTH + SEQ_W + TTL_WIDTH;
   localparam int PAYLOAD_WIDTH  = AURORA_DATA_WIDTH - HEADER_WIDTH;
   localparam int NUMBER_PACKET  = ceil_div(DATA_DFX_WIDTH, PAYLOAD_WIDTH);
   localparam int FRAME_W        = NUMBER_PACKET * PAYLOAD_WIDTH;
   localparam int CH_W           = clog2_min1(NUM_CH);
   localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(NUMBER_PACKET - 1);

   encap_state_e                      state_q, state_d;
   logic [FRAME_W-1:0]                frame_q, frame_d;
   logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid_q, rid_d;
   logic [TTL_WIDTH-1:0]              ttl_q, ttl_d;
   logic [SEQ_W-1:0]                  seq_q, seq_d;
   logic [CH_W-1:0]                   ch_q, ch_d;
   logic [NUM_CH-1:0]                 grant_q;
   logic                              done_q;

   logic [NUM_CH-1:0] gnt_oh;
   logic [CH_W-1:0]   gnt_idx;
   logic              load;
   logic              last;

   encap_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (ch_req),
      .advance (load),
      .grant   (gnt_oh),
      .index   (gnt_idx)
   );

   // FSM next state and datapath next values.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      rid_d   = rid_q;
      ttl_d   = ttl_q;
      seq_d   = seq_q;
      ch_d    = ch_q;
      load    = 1'b0;
      last    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|ch_req) begin
               load    = 1'b1;
               state_d = ST_SEND;
               // Zero-extend {addr, data} up to a whole number of payloads.
               frame_d = '0;
               frame_d[DATA_DFX_WIDTH-1:0] =
                  {ch_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH],
                   ch_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH]};
               rid_d = ch_router_id[int'(gnt_idx)*RECOGNIZE_ROUTER_WIDTH +: RECOGNIZE_ROUTER_WIDTH];
               ttl_d = ch_ttl[int'(gnt_idx)*TTL_WIDTH +: TTL_WIDTH];
               seq_d = '0;
               ch_d  = gnt_idx;
            end
         end
         ST_SEND: begin
            if (data_ready) begin
               // The current beat always sits in the low slice; shift the
               // next one down instead of muxing by sequence number.
               frame_d = frame_q >> PAYLOAD_WIDTH;
               seq_d   = seq_q + SEQ_W'(1);
               if (seq_q == LAST_SEQ) begin
                  last    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         frame_q <= '0;
         rid_q   <= '0;
         ttl_q   <= '0;
         seq_q   <= '0;
         ch_q    <= '0;
         grant_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         rid_q   <= rid_d;
         ttl_q   <= ttl_d;
         seq_q   <= seq_d;
         ch_q    <= ch_d;
         grant_q <= load ? gnt_oh : '0;
         done_q  <= last;
      end
   end

   assign data_encap_valid = (state_q == ST_SEND);
   assign busy             = (state_q == ST_SEND);
   assign data_send        = data_encap_valid ?
                             {rid_q, seq_q, ttl_q, frame_q[PAYLOAD_WIDTH-1:0]} : '0;
   assign ch_grant         = grant_q;
   assign encap_done       = done_q;
   assign encap_ch         = ch_q;
   assign state_dbg        = state_q;

`ifdef ENCAP_PACKET_MC_STATS_EN
   logic [15:0] frame_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      frame_count_q <= '0;
      else if (done_q) frame_count_q <= frame_count_q + 16'd1;
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_encap_packet_mc.sv
// tb_encap_packet_mc: self-checking bench for encap_packet_mc at default
// parameters (19 beats of 64 bits, 55-bit payload, 5-bit sequence field).
module tb_encap_packet_mc;

   localparam int DW  = 1024;
   localparam int AW  = 10;
   localparam int NCH = 4;
   localparam int NP  = 19;
   localparam int PW  = 55;
   localparam int FW  = NP * PW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NCH-1:0]    ch_req;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*2-1:0]  ch_router_id;
   logic [NCH*2-1:0]  ch_ttl;
   logic [NCH-1:0]    ch_grant;
   logic [63:0]       data_send;
   logic              data_encap_valid;
   logic              data_ready;
   logic              encap_done;
   logic [1:0]        encap_ch;
   logic              busy;
   logic              state_dbg;
`ifdef ENCAP_PACKET_MC_STATS_EN
   logic [15:0]       frame_count;
`endif

   encap_packet_mc dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ch_req           (ch_req),
      .ch_data          (ch_data),
      .ch_addr          (ch_addr),
      .ch_router_id     (ch_router_id),
      .ch_ttl           (ch_ttl),
      .ch_grant         (ch_grant),
      .data_send        (data_send),
      .data_encap_valid (data_encap_valid),
      .data_ready       (data_ready),
      .encap_done       (encap_done),
      .encap_ch         (encap_ch),
      .busy             (busy),
`ifdef ENCAP_PACKET_MC_STATS_EN
      .frame_count      (frame_count),
`endif
      .state_dbg        (state_dbg)
   );

   // ---------------- check / counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- channel model ----------------
   logic [DW-1:0] m_data [NCH];
   logic [AW-1:0] m_addr [NCH];
   logic [1:0]    m_rid  [NCH];
   logic [1:0]    m_ttl  [NCH];

   logic [63:0]      exp_q[$];
   logic [1:0]       exp_ch_q[$];
   logic [NCH-1:0]   exp_gnt_q[$];

   function automatic logic [63:0] exp_beat(input int ch, input int k);
      logic [FW-1:0] frame;
      frame = '0;
      frame[DW+AW-1:0] = {m_addr[ch], m_data[ch]};
      return {m_rid[ch], 5'(k), m_ttl[ch], frame[k*PW +: PW]};
   endfunction

   task automatic set_channel(input int ch, input logic [DW-1:0] d, input logic [AW-1:0] a,
                              input logic [1:0] rid, input logic [1:0] ttl);
      m_data[ch] = d;
      m_addr[ch] = a;
      m_rid[ch]  = rid;
      m_ttl[ch]  = ttl;
      ch_data[ch*DW +: DW]    = d;
      ch_addr[ch*AW +: AW]    = a;
      ch_router_id[ch*2 +: 2] = rid;
      ch_ttl[ch*2 +: 2]       = ttl;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Expected frame for a channel, in the order the arbiter should serve it.
   task automatic expect_frame(input int ch);
      logic [NCH-1:0] oh;
      oh = '0;
      oh[ch] = 1'b1;
      exp_gnt_q.push_back(oh);
      for (int k = 0; k < NP; k++) begin
         exp_q.push_back(exp_beat(ch, k));
         exp_ch_q.push_back(2'(ch));
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          cyc = 0;
   int          vcnt = 0;
   int          hcnt = 0;
   int          done_cnt = 0;
   int          grant_cnt = 0;
   int          last_grant_cyc = 0;
   int          last_done_cyc = 0;
   logic        done_due = 1'b0;
   logic        next_due;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;
   logic [1:0]  prev_ch = '0;
   logic [63:0] last_beat = '0;
   logic [63:0] mon_e;
   logic [1:0]  mon_c;

   always @(negedge clk) begin
      cyc++;
      next_due = 1'b0;
      if (rst_n) begin
         if (ch_grant != '0) begin
            grant_cnt++;
            last_grant_cyc = cyc;
            if (exp_gnt_q.size() == 0) check("grant_unexpected", 64'(exp_gnt_q.size()), 64'd1);
            else check("grant_order", 64'(ch_grant), 64'(exp_gnt_q.pop_front()));
            check("busy_at_grant", 64'(busy), 64'd1);
         end
         if (prev_stall && data_encap_valid) begin
            check("stall_data", data_send, prev_data);
            check("stall_ch", 64'(encap_ch), 64'(prev_ch));
         end
         if (data_encap_valid) vcnt++;
         if (data_encap_valid && data_ready) begin
            hcnt++;
            if (exp_q.size() == 0) begin
               check("beat_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
               mon_e = exp_q.pop_front();
               mon_c = exp_ch_q.pop_front();
               check("beat", data_send, mon_e);
               check("encap_ch", 64'(encap_ch), 64'(mon_c));
               if (mon_e[61:57] == 5'(NP - 1)) begin
                  next_due  = 1'b1;
                  last_beat = data_send;
               end
            end
         end
         if (done_due || encap_done) check("encap_done", 64'(encap_done), 64'(done_due));
         if (encap_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            check("busy_at_done", 64'(busy), 64'd0);
         end
         prev_stall = data_encap_valid && !data_ready;
         prev_data  = data_send;
         prev_ch    = encap_ch;
      end else begin
         prev_stall = 1'b0;
      end
      done_due = next_due;
   end

   // ---------------- driver tasks ----------------
   task automatic request(input logic [NCH-1:0] mask);
      @(posedge clk);
      #1;
      ch_req     = mask;
      data_ready = 1'b1;
   endtask

   // release_at == 0: each requester drops on its own grant.
   // release_at  > 0: all requests held until that many grants were seen.
   task automatic run_until(input int target, input bit toggle, input bit rnd,
                            input int release_at, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (release_at == 0) ch_req = ch_req & ~ch_grant;
         else if (grant_cnt >= release_at) ch_req = '0;
         if (toggle) data_ready = ~data_ready;
         else if (rnd) data_ready = ($urandom_range(0, 3) != 0);
      end
      check("wait_done", 64'(done_cnt), 64'(target));
   endtask

   // ---------------- test sequence ----------------
   logic [DW-1:0] incr;
   int            gbase;
   int            dbase;
   int            n;

   initial begin
      rst_n        = 1'b0;
      ch_req       = '0;
      ch_data      = '0;
      ch_addr      = '0;
      ch_router_id = '0;
      ch_ttl       = '0;
      data_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(data_encap_valid), 64'd0);
      check("rst_data", data_send, 64'd0);
      check("rst_done", 64'(encap_done), 64'd0);
      check("rst_grant", 64'(ch_grant), 64'd0);
      check("rst_ch", 64'(encap_ch), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      // Single channel-0 frame, incrementing bytes, addr 0x155, ready high.
      for (int i = 0; i < DW / 8; i++) incr[i*8 +: 8] = 8'(i);
      set_channel(0, incr, 10'h155, 2'd1, 2'd2);
      expect_frame(0);
      hcnt = 0;
      request(4'b0001);
      run_until(1, 1'b0, 1'b0, 0, 200);
      check("t1_handshakes", 64'(hcnt), 64'd19);
      check("t1_grant_to_done", 64'(last_done_cyc - last_grant_cyc), 64'd19);
      check("t1_last_top", 64'(last_beat[54:34]), {43'd0, 11'd0, 10'h155});

      // Channel 1 frame with data_ready toggling, low on the first valid cycle.
      set_channel(1, rand_data(), 10'($urandom_range(0, 1023)), 2'd2, 2'd1);
      expect_frame(1);
      hcnt = 0;
      vcnt = 0;
      request(4'b0010);
      run_until(2, 1'b1, 1'b0, 0, 200);
      check("t2_handshakes", 64'(hcnt), 64'd19);
      check("t2_valid_cycles", 64'(vcnt), 64'd38);

      // Channel 3 frame, reset asserted while beat 7 is on the bus.
      set_channel(3, rand_data(), 10'($urandom_range(0, 1023)), 2'd3, 2'd3);
      expect_frame(3);
      hcnt = 0;
      request(4'b1000);
      n = 0;
      while (hcnt < 7 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         ch_req = ch_req & ~ch_grant;
      end
      check("t3_reached_beat7", 64'(hcnt), 64'd7);
      #1;
      rst_n = 1'b0;
      #1;
      check("t3_valid_async", 64'(data_encap_valid), 64'd0);
      check("t3_busy_async", 64'(busy), 64'd0);
      check("t3_data_async", data_send, 64'd0);
      check("t3_ch_async", 64'(encap_ch), 64'd0);
      exp_q.delete();
      exp_ch_q.delete();
      exp_gnt_q.delete();
      dbase = done_cnt;
      ch_req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t3_no_done", 64'(done_cnt), 64'(dbase));

      // All four channels request continuously; arbiter restarts at channel 0.
      for (int c = 0; c < NCH; c++)
         set_channel(c, rand_data(), 10'($urandom_range(0, 1023)), 2'(c), 2'($urandom_range(0, 3)));
      expect_frame(0);
      expect_frame(1);
      expect_frame(2);
      expect_frame(3);
      expect_frame(0);
      gbase = grant_cnt;
      request(4'b1111);
      run_until(done_cnt + 5, 1'b0, 1'b1, gbase + 5, 1000);
      check("t4_grants", 64'(grant_cnt - gbase), 64'd5);
      repeat (3) @(posedge clk);
      #1;
      check("t4_idle_busy", 64'(busy), 64'd0);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef ENCAP_PACKET_MC_STATS_EN
      check("frame_count", 64'(frame_count), 64'(done_cnt - dbase));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/encap_packet_mc.md
ENCAP_PACKET_MC -- requirements
Module: encap_packet_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1024, payload bits per frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, router destination address bits.
REQ-003 SHALL have parameter NUM_CH, default 4, number of requesting channels (>=1).
REQ-004 SHALL have parameter RECOGNIZE_ROUTER_WIDTH, default 2, router-id header field.
REQ-005 SHALL have parameter TTL_WIDTH, default 2, TTL header field.
REQ-006 SHALL have parameter AURORA_DATA_WIDTH, default 64, output beat width.
REQ-007 SHALL derive DATA_DFX_WIDTH=DATA_WIDTH+ADDR_WIDTH, HEADER_WIDTH=RECOGNIZE_ROUTER_WIDTH+SEQ_W+TTL_WIDTH, PAYLOAD_WIDTH=AURORA_DATA_WIDTH-HEADER_WIDTH, NUMBER_PACKET=ceil(DATA_DFX_WIDTH/PAYLOAD_WIDTH), SEQ_W=$clog2(NUMBER_PACKET) (defaults: 19 beats, 55-bit payload).
REQ-008 SHALL use one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-009 ports: ch_req input NUM_CH frame request per channel; ch_data input NUM_CH*DATA_WIDTH flattened frame data; ch_addr input NUM_CH*ADDR_WIDTH destination addresses; ch_router_id input NUM_CH*RECOGNIZE_ROUTER_WIDTH; ch_ttl input NUM_CH*TTL_WIDTH; ch_grant output NUM_CH one-cycle capture pulse; data_send output AURORA_DATA_WIDTH beat; data_encap_valid output 1; data_ready input 1 sink ready; encap_done output 1 frame-complete pulse; encap_ch output $clog2(NUM_CH) (min 1) channel in service; busy output 1.

Function
REQ-010 SHALL form frame word {addr, data} (addr in MSBs), zero-extended to NUMBER_PACKET*PAYLOAD_WIDTH.
REQ-011 SHALL emit beat k (k=0..NUMBER_PACKET-1) as {router_id, k, ttl, frame[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]}, beat 0 = LSB slice.
REQ-012 SHALL implement FSM IDLE/SEND: IDLE with any ch_req -> capture granted channel, pulse ch_grant, go SEND; SEND -> IDLE on handshake of last beat.
REQ-013 SHALL arbitrate round-robin: search starts at channel after last granted; after reset search starts at channel 0.
REQ-014 SHALL assert data_encap_valid from the cycle after capture until last beat handshake; beat advances only on data_encap_valid && data_ready.
REQ-015 SHALL hold data_send and encap_ch stable while data_encap_valid && !data_ready.
REQ-016 SHALL pulse encap_done for exactly one cycle, the cycle after the last-beat handshake; FSM is IDLE in that cycle and may grant again.
REQ-017 SHALL ignore ch_req while in SEND; requester must hold ch_req until ch_grant; capture is registered so ch_data may change after grant.
REQ-018 SHALL drive busy=1 in SEND, 0 in IDLE.
REQ-019 SHALL sustain one beat per cycle with data_ready tied high: frame of NUMBER_PACKET beats occupies NUMBER_PACKET cycles plus one capture cycle.

Reset
REQ-020 SHALL on rst_n low force IDLE, data_send=0, data_encap_valid=0, encap_done=0, ch_grant=0, encap_ch=0, busy=0, RR pointer=0.
REQ-021 SHALL discard any in-flight frame on reset mid-frame; no encap_done issued for it.

Configuration
REQ-022 SHALL compile, when ENCAP_PACKET_MC_STATS_EN is defined, output frame_count[15:0] incremented with each encap_done, wrapping 0xFFFF->0, reset to 0.
REQ-023 SHALL omit frame_count port and logic when ENCAP_PACKET_MC_STATS_EN is undefined; all other behaviour identical.

Structure
REQ-024 SHALL place derived-width functions and FSM state encoding in shared package encap_pkg.
REQ-025 SHALL implement arbitration in sub-module encap_rr_arbiter (req, advance -> one-hot grant, index).

Verification
REQ-026 Single channel 0 frame, data=incrementing bytes, addr=0x155, data_ready=1 -> 19 beats, seq 0..18, beat 18 top payload bits = addr then zero pad, encap_done one cycle after beat 18.
REQ-027 data_ready toggled 1/0 each cycle -> data_send stable during stalls, 19 handshakes, 38 cycles of valid.
REQ-028 All 4 channels request continuously -> grant order 0,1,2,3,0; encap_ch matches header router_id per channel.
REQ-029 rst_n low at beat 7 -> valid drops asynchronously, no encap_done; next request starts at seq 0, channel 0.
REQ-030 With ENCAP_PACKET_MC_STATS_EN, 65537 frames -> frame_count=1; without macro, port absent and build passes.
